// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, captures the combinational memory word into an
// output register, hands it to decode over valid/ready, and resolves JMP/CALL/RET locally.
module instr_fetch_unit #(
  parameter int                ADDR_W      = 19,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [18:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [18:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              br_valid,
  input  logic              br_taken,
  output logic              stalled,
  output logic              halted,
  output logic [1:0]        err_code
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LD   = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_BEQ  = 5'b00011;
  localparam logic [4:0] OP_BNE  = 5'b00100;
  localparam logic [4:0] OP_JMP  = 5'b00101;
  localparam logic [4:0] OP_CALL = 5'b00110;
  localparam logic [4:0] OP_RET  = 5'b00111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_UNDER   = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT_BR,
    S_HALT
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              out_valid_reg, out_valid_next;
  logic [18:0]       out_instr_reg, out_instr_next;
  logic [ADDR_W-1:0] out_pc_reg, out_pc_next;
  logic [SP_W-1:0]   sp_reg, sp_next;
  logic [ADDR_W-1:0] br_pc_reg, br_pc_next;
  logic [7:0]        br_off_reg, br_off_next;
  logic [1:0]        err_reg, err_next;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;

  logic              capture;
  logic              emit;
  logic [4:0]        opcode;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] br_off_ext;
  logic              stack_full;
  logic              stack_empty;

  assign capture     = !out_valid_reg || out_ready;
  assign opcode      = imem_rdata[18:14];
  assign pc_inc      = pc_reg + ADDR_W'(1);
  assign jump_target = ADDR_W'(imem_rdata[13:0]);
  assign br_off_ext  = {{(ADDR_W-8){br_off_reg[7]}}, br_off_reg};
  assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_reg == '0);
  assign push_idx    = sp_reg[IDX_W-1:0];
  assign top_idx     = IDX_W'(sp_reg - SP_W'(1));

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    out_valid_next = out_valid_reg;
    out_instr_next = out_instr_reg;
    out_pc_next    = out_pc_reg;
    sp_next        = sp_reg;
    br_pc_next     = br_pc_reg;
    br_off_next    = br_off_reg;
    err_next       = err_reg;
    push_en        = 1'b0;
    emit           = 1'b0;

    // The held word drains on any handshake, whatever state the fetch side is in.
    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      S_FETCH: begin
        if (capture) begin
          case (opcode)
            OP_ALU, OP_LD, OP_ST: begin
              emit    = 1'b1;
              pc_next = pc_inc;
            end
            OP_BEQ, OP_BNE: begin
              emit        = 1'b1;
              br_pc_next  = pc_reg;
              br_off_next = imem_rdata[7:0];
              state_next  = S_WAIT_BR;
            end
            OP_JMP: begin
              emit    = 1'b1;
              pc_next = jump_target;
            end
            OP_CALL: begin
              if (stack_full) begin
                state_next = S_HALT;
                err_next   = ERR_OVER;
              end else begin
                emit    = 1'b1;
                push_en = 1'b1;
                sp_next = sp_reg + SP_W'(1);
                pc_next = jump_target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                state_next = S_HALT;
                err_next   = ERR_UNDER;
              end else begin
                emit    = 1'b1;
                sp_next = sp_reg - SP_W'(1);
                pc_next = stack_mem[top_idx];
              end
            end
            default: begin
              state_next = S_HALT;
              err_next   = ERR_ILLEGAL;
            end
          endcase
          if (emit) begin
            out_valid_next = 1'b1;
            out_instr_next = imem_rdata;
            out_pc_next    = pc_reg;
          end
        end
      end
      S_WAIT_BR: begin
        if (br_valid) begin
          pc_next    = br_taken ? (br_pc_reg + ADDR_W'(1) + br_off_ext)
                                : (br_pc_reg + ADDR_W'(1));
          state_next = S_FETCH;
        end
      end
      S_HALT: begin
      end
      default: begin
        state_next = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_FETCH;
      pc_reg        <= RESET_PC;
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_pc_reg    <= '0;
      sp_reg        <= '0;
      br_pc_reg     <= '0;
      br_off_reg    <= '0;
      err_reg       <= ERR_NONE;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      out_valid_reg <= out_valid_next;
      out_instr_reg <= out_instr_next;
      out_pc_reg    <= out_pc_next;
      sp_reg        <= sp_next;
      br_pc_reg     <= br_pc_next;
      br_off_reg    <= br_off_next;
      err_reg       <= err_next;
    end
  end

  // Entry contents need no reset: only slots below the stack pointer are ever read.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign imem_addr = pc_reg;
  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_pc    = out_pc_reg;
  assign stalled   = (state_reg == S_WAIT_BR);
  assign halted    = (state_reg == S_HALT);
  assign err_code  = err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle vector table, directed corner sequences, and
// random programs checked against an instruction-level interpreter of the fetch rules.
module tb_instr_fetch_unit;

  localparam int LIMIT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_instr;
  logic [18:0] out_pc;
  logic        br_valid;
  logic        br_taken;
  logic        stalled;
  logic        halted;
  logic [1:0]  err_code;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .stalled    (stalled),
    .halted     (halted),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  logic [18:0] mem [0:1023];
  assign imem_rdata = mem[imem_addr[9:0]];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] mk(input int op, input int f);
    logic [4:0]  o;
    logic [13:0] ff;
    o  = 5'(op);
    ff = 14'(f);
    return {o, ff};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b0;
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = mk(0, i);
  endtask

  typedef struct packed {
    logic        rdy;
    logic        bv;
    logic        bt;
    logic        ev;
    logic [18:0] epc;
    logic [18:0] eopc;
    logic        es;
  } vec_t;

  function automatic vec_t mkv(input bit r, input bit bv, input bit bt, input bit ev,
                               input int pc, input int opc, input bit s);
    vec_t v;
    v.rdy  = r;
    v.bv   = bv;
    v.bt   = bt;
    v.ev   = ev;
    v.epc  = 19'(pc);
    v.eopc = 19'(opc);
    v.es   = s;
    return v;
  endfunction

  vec_t vt [21];

  // Random-phase reference state
  logic [37:0] exp_q [$];
  logic [18:0] stk [$];
  bit          taken_tab [64];
  logic [1:0]  exp_err;
  bit          exp_halt;

  function automatic logic [18:0] rand_instr();
    int r;
    int off;
    r = $urandom_range(0, 99);
    off = int'($urandom_range(0, 12)) - 6;
    if (r < 50)      return mk($urandom_range(0, 2), $urandom);
    else if (r < 60) return mk(3, {6'($urandom), 8'(off)});
    else if (r < 70) return mk(4, {6'($urandom), 8'(off)});
    else if (r < 78) return mk(5, $urandom_range(0, 40));
    else if (r < 88) return mk(6, $urandom_range(0, 40));
    else if (r < 97) return mk(7, $urandom);
    else             return mk($urandom_range(8, 31), $urandom);
  endfunction

  // Architectural interpreter: walks the program and lists what decode should receive.
  task automatic run_model();
    logic [18:0] pc;
    logic [18:0] w;
    int          op;
    int          bi;
    exp_q.delete();
    stk.delete();
    exp_err  = 2'b00;
    exp_halt = 0;
    pc = 19'd0;
    bi = 0;
    while (exp_q.size() < LIMIT) begin
      w  = mem[pc[9:0]];
      op = int'(w[18:14]);
      if (op > 7) begin exp_err = 2'b01; exp_halt = 1; break; end
      if (op == 6 && stk.size() == 4) begin exp_err = 2'b10; exp_halt = 1; break; end
      if (op == 7 && stk.size() == 0) begin exp_err = 2'b11; exp_halt = 1; break; end
      exp_q.push_back({pc, w});
      case (op)
        3, 4: begin
          if (taken_tab[bi]) pc = pc + 19'd1 + 19'(signed'(w[7:0]));
          else               pc = pc + 19'd1;
          bi++;
        end
        5: pc = 19'(w[13:0]);
        6: begin stk.push_back(pc + 19'd1); pc = 19'(w[13:0]); end
        7: pc = stk.pop_back();
        default: pc = pc + 19'd1;
      endcase
    end
  endtask

  task automatic run_random();
    int          got;
    int          bi;
    int          dly;
    bit          done;
    bit          hs;
    logic [37:0] cap;
    clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = rand_instr();
    for (int i = 0; i < 64; i++) taken_tab[i] = 1'($urandom);
    run_model();
    do_reset();
    got  = 0;
    bi   = 0;
    dly  = -1;
    done = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      if (stalled) begin
        if (dly < 0) dly = $urandom_range(0, 3);
        if (dly == 0) begin
          br_valid = 1'b1;
          br_taken = (bi < 64) ? taken_tab[bi] : 1'b0;
          bi++;
          dly = -1;
        end else begin
          dly--;
        end
      end
      hs  = out_valid && out_ready;
      cap = {out_pc, out_instr};
      tick();
      if (hs) begin
        if (got < exp_q.size()) chk("rand_xfer", cap, exp_q[got]);
        else                    chk("rand_extra", 64'(got), 64'(exp_q.size()));
        got++;
      end
      if (exp_halt) done = (got >= exp_q.size()) && halted;
      else          done = (got >= exp_q.size());
    end
    chk("rand_done", 64'(done), 64'd1);
    if (exp_halt) chk("rand_err", 64'(err_code), 64'(exp_err));
  endtask

  initial begin
    int          emits;
    logic [18:0] last_pc;

    // Table program: straight line, backpressure, branches, call/ret, jumps
    clear_mem();
    mem[0]  = mk(0, 14'h0123);
    mem[1]  = mk(1, 14'h0456);
    mem[2]  = mk(2, 14'h0789);
    mem[3]  = mk(3, 14'h0003);
    mem[4]  = mk(0, 14'h0444);
    mem[5]  = mk(4, 14'h00FE);
    mem[6]  = mk(5, 8);
    mem[7]  = mk(6, 10);
    mem[8]  = mk(5, 5);
    mem[10] = mk(7, 0);

    vt[0]  = mkv(1, 0, 0, 1, 1, 0, 0);
    vt[1]  = mkv(1, 0, 0, 1, 2, 1, 0);
    vt[2]  = mkv(0, 0, 0, 1, 2, 1, 0);
    vt[3]  = mkv(0, 0, 0, 1, 2, 1, 0);
    vt[4]  = mkv(0, 0, 0, 1, 2, 1, 0);
    vt[5]  = mkv(1, 0, 0, 1, 3, 2, 0);
    vt[6]  = mkv(1, 0, 0, 1, 3, 3, 1);
    vt[7]  = mkv(1, 0, 0, 0, 3, 0, 1);
    vt[8]  = mkv(1, 1, 1, 0, 7, 0, 0);
    vt[9]  = mkv(1, 0, 0, 1, 10, 7, 0);
    vt[10] = mkv(1, 0, 0, 1, 8, 10, 0);
    vt[11] = mkv(1, 0, 0, 1, 5, 8, 0);
    vt[12] = mkv(1, 0, 0, 1, 5, 5, 1);
    vt[13] = mkv(1, 1, 1, 0, 4, 0, 0);
    vt[14] = mkv(1, 0, 0, 1, 5, 4, 0);
    vt[15] = mkv(1, 0, 0, 1, 5, 5, 1);
    vt[16] = mkv(0, 0, 0, 1, 5, 5, 1);
    vt[17] = mkv(0, 1, 0, 1, 6, 5, 0);
    vt[18] = mkv(0, 0, 0, 1, 6, 5, 0);
    vt[19] = mkv(1, 0, 0, 1, 8, 6, 0);
    vt[20] = mkv(1, 1, 1, 1, 5, 8, 0);

    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_stalled", 64'(stalled), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_err", 64'(err_code), 64'd0);

    for (int i = 0; i < 21; i++) begin
      out_ready = vt[i].rdy;
      br_valid  = vt[i].bv;
      br_taken  = vt[i].bt;
      tick();
      $display("vec %0d: valid=%0d addr=%0d out_pc=%0d stalled=%0d", i, out_valid, imem_addr, out_pc, stalled);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(vt[i].ev));
      chk($sformatf("tbl%0d_addr", i), 64'(imem_addr), 64'(vt[i].epc));
      chk($sformatf("tbl%0d_stalled", i), 64'(stalled), 64'(vt[i].es));
      chk($sformatf("tbl%0d_halted", i), 64'(halted), 64'd0);
      if (vt[i].ev) begin
        chk($sformatf("tbl%0d_out_pc", i), 64'(out_pc), 64'(vt[i].eopc));
        chk($sformatf("tbl%0d_instr", i), 64'(out_instr), 64'(mem[vt[i].eopc[9:0]]));
      end
    end
    br_valid = 1'b0;
    br_taken = 1'b0;

    // Five nested CALLs with a four-entry stack: the fifth must not be emitted
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = mk(6, i + 1);
    do_reset();
    out_ready = 1'b1;
    emits   = 0;
    last_pc = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) begin emits++; last_pc = out_pc; end
    end
    $display("overflow: emits=%0d last_pc=%0d halted=%0d err=%0d", emits, last_pc, halted, err_code);
    chk("ovf_emits", 64'(emits), 64'd4);
    chk("ovf_last_pc", 64'(last_pc), 64'd3);
    chk("ovf_halted", 64'(halted), 64'd1);
    chk("ovf_err", 64'(err_code), 64'd2);

    // RET straight out of reset
    clear_mem();
    mem[0] = mk(7, 0);
    do_reset();
    out_ready = 1'b1;
    tick();
    chk("und_halted", 64'(halted), 64'd1);
    chk("und_err", 64'(err_code), 64'd3);
    chk("und_valid", 64'(out_valid), 64'd0);
    tick();
    chk("und_sticky", 64'(halted), 64'd1);
    $display("underflow: halted=%0d err=%0d", halted, err_code);

    // Illegal opcode behind a held instruction that drains first
    clear_mem();
    mem[1] = mk(8, 0);
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    chk("ill_hold_halted", 64'(halted), 64'd0);
    chk("ill_hold_pc", 64'(out_pc), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("ill_halted", 64'(halted), 64'd1);
    chk("ill_err", 64'(err_code), 64'd1);
    chk("ill_valid", 64'(out_valid), 64'd0);
    $display("illegal: halted=%0d err=%0d", halted, err_code);

    // Reset while waiting on a branch, with one stack entry live
    clear_mem();
    mem[0] = mk(6, 2);
    mem[2] = mk(3, 0);
    do_reset();
    out_ready = 1'b1;
    tick();
    tick();
    chk("rwb_stalled", 64'(stalled), 64'd1);
    rst = 1'b1;
    tick();
    chk("rwb_addr", 64'(imem_addr), 64'd0);
    chk("rwb_valid", 64'(out_valid), 64'd0);
    chk("rwb_stalled0", 64'(stalled), 64'd0);
    chk("rwb_halted", 64'(halted), 64'd0);
    rst = 1'b0;
    mem[0] = mk(7, 0);
    tick();
    chk("rwb_stack_empty", 64'(err_code), 64'd3);
    $display("reset in wait: err=%0d", err_code);

    // Negative branch offset wraps below zero, then pc+1 wraps back to zero
    clear_mem();
    mem[0]    = mk(3, 14'h00FE);
    mem[1023] = mk(0, 14'h0777);
    do_reset();
    out_ready = 1'b1;
    tick();
    br_valid = 1'b1;
    br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    chk("wrap_addr", 64'(imem_addr), 64'h7FFFF);
    tick();
    chk("wrap_out_pc", 64'(out_pc), 64'h7FFFF);
    chk("wrap_instr", 64'(out_instr), 64'(mem[1023]));
    chk("wrap_addr0", 64'(imem_addr), 64'd0);
    $display("wrap: out_pc=%0h addr=%0h", out_pc, imem_addr);

    for (int p = 0; p < 30; p++) begin
      run_random();
      $display("random program %0d: expected=%0d halt=%0d err=%0d", p, exp_q.size(), exp_halt, exp_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
